mac_sched: RTL

Sequencer and round-robin arbiter that shares one `mac` datapath between `NREQ` requesters running dot-product jobs. Each granted job clears the accumulator, streams operand pairs into `mac` as multiply-accumulate ops, drains the pipeline, and returns the 32-bit sum with an overflow flag. It sits between the requester streams and the single `mac` instance and drives all of that instance's control inputs.

---
 rtl/mac_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/mac_sched.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// mac_pkg: opcodes, sequencer states and saturation limits shared by mac_sched.
package mac_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_CLR = 3'b100;
  localparam logic [2:0] OP_MAC = 3'b110;

  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    oh2idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) oh2idx = 3'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// rr_arbiter: rotating-priority one-hot arbiter; advance moves priority past the current grant.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_nxt;
  logic [2*NREQ-1:0] req_rot;
  logic [2*NREQ-1:0] gnt_rot;
  logic [NREQ-1:0]   sel;
  logic              found;

  // Rotate requests so ptr sits at bit 0, pick the first set bit, rotate back.
  always_comb begin
    req_rot = {req, req} >> ptr;
    sel     = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_rot[i]) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
    gnt_rot = {{NREQ{1'b0}}, sel} << ptr;
    grant   = gnt_rot[NREQ-1:0] | gnt_rot[2*NREQ-1:NREQ];
    ptr_nxt = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) ptr_nxt = PW'((i + 1) % NREQ);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_sched.sv
`default_nettype none
// mac_sched: shares one mac datapath among NREQ requesters running dot-product jobs.
// Define MAC_SCHED_SAT_EN to saturate res_data when the accumulator overflows.
module mac_sched
  import mac_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int MAC_LAT = 2,
  parameter int LEN_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [16*NREQ-1:0]       req_a,
  input  logic [16*NREQ-1:0]       req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic [2:0]               mac_instruction,
  output logic [15:0]              mac_multiplier,
  output logic [15:0]              mac_multiplicand,
  output logic                     mac_stall,
  input  logic [7:0]               mac_protect,
  input  logic [31:0]              mac_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic [31:0]              res_data,
  output logic                     res_ovf,
  output logic [LEN_W-1:0]         res_len
);
  localparam int IW = $clog2(NREQ);
  localparam int DW = $clog2(MAC_LAT + 1);

  state_t          state;
  logic [NREQ-1:0] grant_r;
  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   gidx;
  logic [LEN_W-1:0] cnt;
  logic [DW-1:0]   dcnt;
  logic            hs;
  logic            advance;
  logic            ovf;
  logic [31:0]     res_next;

  // While a job runs the held grant keeps requesting, so acceptance rotates past it.
  assign arb_req = (state == ST_IDLE) ? req_valid : grant_r;
  assign advance = (state == ST_DONE) && res_ready;
  assign hs      = (state == ST_RUN) && req_valid[gidx] && req_ready[gidx];
  assign ovf     = !(((mac_protect == 8'h00) && !mac_result[31]) ||
                     ((mac_protect == 8'hFF) &&  mac_result[31]));

`ifdef MAC_SCHED_SAT_EN
  assign res_next = ovf ? (mac_protect[7] ? SAT_NEG : SAT_POS) : mac_result;
`else
  assign res_next = mac_result;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (advance),
    .grant   (arb_grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      grant_r          <= '0;
      gidx             <= '0;
      cnt              <= '0;
      dcnt             <= '0;
      req_ready        <= '0;
      mac_instruction  <= OP_NOP;
      mac_multiplier   <= '0;
      mac_multiplicand <= '0;
      mac_stall        <= 1'b1;
      res_valid        <= 1'b0;
      res_id           <= '0;
      res_data         <= '0;
      res_ovf          <= 1'b0;
      res_len          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          mac_instruction <= OP_NOP;
          mac_stall       <= 1'b1;
          if (|req_valid) begin
            grant_r         <= arb_grant;
            gidx            <= IW'(oh2idx(8'(arb_grant)));
            cnt             <= '0;
            mac_instruction <= OP_CLR;
            mac_stall       <= 1'b0;
            state           <= ST_CLR;
          end
        end
        ST_CLR: begin
          req_ready       <= grant_r;
          mac_instruction <= OP_NOP;
          mac_stall       <= 1'b1;
          state           <= ST_RUN;
        end
        ST_RUN: begin
          if (hs) begin
            mac_instruction  <= OP_MAC;
            mac_multiplier   <= req_a[{gidx, 4'b0000} +: 16];
            mac_multiplicand <= req_b[{gidx, 4'b0000} +: 16];
            mac_stall        <= 1'b0;
            if (cnt != '1) cnt <= cnt + 1'b1;
            if (req_last[gidx]) begin
              req_ready <= '0;
              dcnt      <= '0;
              state     <= ST_DRAIN;
            end
          end else begin
            mac_instruction <= OP_NOP;
            mac_stall       <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // First DRAIN cycle still shows the last MAC; MAC_LAT NOP cycles follow.
          mac_instruction <= OP_NOP;
          if (dcnt == DW'(MAC_LAT)) begin
            mac_stall <= 1'b1;
            res_valid <= 1'b1;
            res_data  <= res_next;
            res_ovf   <= ovf;
            res_len   <= cnt;
            res_id    <= gidx;
            state     <= ST_DONE;
          end else begin
            mac_stall <= 1'b0;
            dcnt      <= dcnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
